// File: rtl/uart_mem_loader.sv
// -----------------------------------------------------------------------------
// uart_mem_loader
//
// Decodes the host byte stream arriving from the UART receiver into 32-bit
// memory write requests, and latches the host "go" command into the core's
// fetch enable.
//
// Frame format (all fields MSB first):
//   0x02 A3 A2 A1 A0 D3 D2 D1 D0 [D3 D2 D1 D0 ...]   write burst
//   0x04                                             go (sets fetch_en)
//   0x00                                             ignored
// A burst writes consecutive words from the (word-aligned) start address and
// always stops after the word that lands on the last word of a 16-byte block.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   rx_valid     one-cycle strobe, rx_data holds a received byte
//   rx_data      received byte
//   mem_req      write request (held until granted)
//   mem_addr     word address of the request, bits [1:0] always 0
//   mem_wdata    write data of the request
//   mem_be       byte enables, always 4'hF
//   mem_gnt      request accepted this cycle
//   fetch_en     core fetch enable, sticky until reset
//   word_cnt     number of granted writes (wraps)
//   err_overrun  sticky: a word was dropped because the slot was busy
//   err_cmd      sticky: unknown command byte seen in IDLE
//   err_timeout  sticky: a frame was abandoned after TIMEOUT_CYCLES idle
// -----------------------------------------------------------------------------
module uart_mem_loader #(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    output logic             mem_req,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_be,
    input  logic             mem_gnt,
    output logic             fetch_en,
    output logic [CNT_W-1:0] word_cnt,
    output logic             err_overrun,
    output logic             err_cmd,
    output logic             err_timeout
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADDR = 2'd1;
    localparam logic [1:0] DATA = 2'd2;

    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [7:0] CMD_NOP   = 8'h00;
    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_GO    = 8'h04;

    logic [1:0]       state_reg;
    logic [1:0]       byte_cnt_reg;
    logic [31:0]      shift_reg;
    logic [31:0]      addr_reg;
    logic [TMR_W-1:0] timer_reg;

    logic             req_reg;
    logic [31:0]      req_addr_reg;
    logic [31:0]      req_data_reg;
    logic             fetch_en_reg;
    logic [CNT_W-1:0] word_cnt_reg;
    logic             err_overrun_reg;
    logic             err_cmd_reg;
    logic             err_timeout_reg;

    logic        last_byte;
    logic [31:0] assembled;
    logic        timeout_hit;
    logic        word_done;
    logic        slot_free;
    logic        grant;

    // The incoming byte completes the field being shifted in when the byte
    // counter is already at 3; the full field is then the shift register's
    // lower three bytes with the new byte appended.
    assign last_byte   = (byte_cnt_reg == 2'd3);
    assign assembled   = {shift_reg[23:0], rx_data};
    // A byte arriving in the same cycle always wins over the timeout.
    assign timeout_hit = (state_reg != IDLE) && !rx_valid &&
                         (timer_reg == TMR_W'(TIMEOUT_CYCLES - 1));
    assign word_done   = rx_valid && (state_reg == DATA) && last_byte;
    // A slot being granted this cycle can be refilled in the same cycle.
    assign slot_free   = !req_reg || mem_gnt;
    assign grant       = req_reg && mem_gnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            byte_cnt_reg    <= 2'd0;
            shift_reg       <= 32'd0;
            addr_reg        <= 32'd0;
            timer_reg       <= '0;
            req_reg         <= 1'b0;
            req_addr_reg    <= 32'd0;
            req_data_reg    <= 32'd0;
            fetch_en_reg    <= 1'b0;
            word_cnt_reg    <= '0;
            err_overrun_reg <= 1'b0;
            err_cmd_reg     <= 1'b0;
            err_timeout_reg <= 1'b0;
        end else begin
            // ---------------- request stage ----------------
            if (word_done && slot_free) begin
                req_reg      <= 1'b1;
                req_addr_reg <= addr_reg;
                req_data_reg <= assembled;
            end else if (grant) begin
                req_reg <= 1'b0;
            end

            if (word_done && !slot_free) begin
                err_overrun_reg <= 1'b1;
            end

            if (grant) begin
                word_cnt_reg <= word_cnt_reg + 1'b1;
            end

            // ---------------- inter-byte timer ----------------
            if (state_reg == IDLE || rx_valid || timeout_hit) begin
                timer_reg <= '0;
            end else begin
                timer_reg <= timer_reg + 1'b1;
            end

            // ---------------- frame parser ----------------
            case (state_reg)
                IDLE: begin
                    if (rx_valid) begin
                        case (rx_data)
                            CMD_WRITE: begin
                                state_reg    <= ADDR;
                                byte_cnt_reg <= 2'd0;
                            end
                            CMD_GO:  fetch_en_reg <= 1'b1;
                            CMD_NOP: ;
                            default: err_cmd_reg <= 1'b1;
                        endcase
                    end
                end

                ADDR: begin
                    if (timeout_hit) begin
                        state_reg       <= IDLE;
                        byte_cnt_reg    <= 2'd0;
                        err_timeout_reg <= 1'b1;
                    end else if (rx_valid) begin
                        shift_reg    <= assembled;
                        byte_cnt_reg <= byte_cnt_reg + 2'd1;
                        if (last_byte) begin
                            addr_reg  <= {assembled[31:2], 2'b00};
                            state_reg <= DATA;
                        end
                    end
                end

                DATA: begin
                    if (timeout_hit) begin
                        state_reg       <= IDLE;
                        byte_cnt_reg    <= 2'd0;
                        err_timeout_reg <= 1'b1;
                    end else if (rx_valid) begin
                        shift_reg    <= assembled;
                        byte_cnt_reg <= byte_cnt_reg + 2'd1;
                        if (last_byte) begin
                            // The address advances even when the word was
                            // dropped, so the burst geometry never depends on
                            // memory back-pressure.
                            addr_reg <= addr_reg + 32'd4;
                            if (addr_reg[3:2] == 2'b11) begin
                                state_reg <= IDLE;
                            end
                        end
                    end
                end

                default: begin
                    state_reg    <= IDLE;
                    byte_cnt_reg <= 2'd0;
                end
            endcase
        end
    end

    assign mem_req     = req_reg;
    assign mem_addr    = req_addr_reg;
    assign mem_wdata   = req_data_reg;
    assign mem_be      = 4'hF;
    assign fetch_en    = fetch_en_reg;
    assign word_cnt    = word_cnt_reg;
    assign err_overrun = err_overrun_reg;
    assign err_cmd     = err_cmd_reg;
    assign err_timeout = err_timeout_reg;

endmodule

// File: tb/tb_uart_mem_loader.sv
// -----------------------------------------------------------------------------
// tb_uart_mem_loader
//
// Self-checking bench for uart_mem_loader. Stimulus pushes the expected
// {address, data} of every write it intends to produce into a queue; an
// independent monitor pops and compares on every granted request.
// -----------------------------------------------------------------------------
module tb_uart_mem_loader;

    localparam int TMO   = 500;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             rx_valid;
    logic [7:0]       rx_data;
    logic             mem_req;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic [3:0]       mem_be;
    logic             mem_gnt;
    logic             fetch_en;
    logic [CNT_W-1:0] word_cnt;
    logic             err_overrun;
    logic             err_cmd;
    logic             err_timeout;

    int n_cmp = 0;
    int n_bad = 0;
    logic [63:0] exp_q[$];

    uart_mem_loader #(.TIMEOUT_CYCLES(TMO), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_be      (mem_be),
        .mem_gnt     (mem_gnt),
        .fetch_en    (fetch_en),
        .word_cnt    (word_cnt),
        .err_overrun (err_overrun),
        .err_cmd     (err_cmd),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Monitor: a grant is taken at the next rising edge whenever req and gnt
    // are both high at the falling edge.
    always @(negedge clk) begin
        if (!reset && mem_req && mem_gnt) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL write_unexpected: got addr %h data %h expected none", mem_addr, mem_wdata);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("write_addr", mem_addr, e[63:32]);
                check("write_data", mem_wdata, e[31:0]);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_hdr(input logic [31:0] a);
        send_byte(8'h02);
        send_byte(a[31:24]);
        send_byte(a[23:16]);
        send_byte(a[15:8]);
        send_byte(a[7:0]);
    endtask

    task automatic send_word(input logic [31:0] a, input logic [31:0] d, input bit push);
        if (push) exp_q.push_back({a, d});
        send_byte(d[31:24]);
        send_byte(d[23:16]);
        send_byte(d[15:8]);
        send_byte(d[7:0]);
    endtask

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        mem_gnt  = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // ---------------- reset values ----------------
        @(negedge clk);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_mem_be", {28'd0, mem_be}, 32'hF);
        check("rst_fetch_en", {31'd0, fetch_en}, 32'd0);
        check("rst_word_cnt", {16'd0, word_cnt}, 32'd0);
        check("rst_errs", {29'd0, err_overrun, err_cmd, err_timeout}, 32'd0);
        tick(1);

        // ---------------- single frame, gnt tied high ----------------
        mem_gnt = 1'b1;
        send_hdr(32'h0000_0000);
        send_word(32'h0, 32'h1122_3344, 1'b1);
        check("latency_req", {31'd0, mem_req}, 32'd1);
        send_word(32'h4, 32'h5566_7788, 1'b1);
        send_word(32'h8, 32'h99AA_BBCC, 1'b1);
        send_word(32'hC, 32'hDDEE_FF00, 1'b1);
        tick(3);
        check("single_word_cnt", {16'd0, word_cnt}, 32'd4);
        check("single_idle", {30'd0, dut.state_reg}, 32'd0);
        check("single_req_low", {31'd0, mem_req}, 32'd0);
        check("single_no_errs", {29'd0, err_overrun, err_cmd, err_timeout}, 32'd0);

        // ---------------- unaligned start ----------------
        send_hdr(32'h0000_000B);
        send_word(32'h8, 32'h0102_0305, 1'b1);
        send_word(32'hC, 32'hA5A5_5A5A, 1'b1);
        check("unal_idle", {30'd0, dut.state_reg}, 32'd0);
        send_word(32'h10, 32'hDEAD_BEEF, 1'b0);
        tick(2);
        check("unal_err_cmd", {31'd0, err_cmd}, 32'd1);
        check("unal_word_cnt", {16'd0, word_cnt}, 32'd6);

        // ---------------- back-pressure and overrun ----------------
        mem_gnt = 1'b0;
        send_hdr(32'h0000_0020);
        send_word(32'h20, 32'hA1B2_C3D4, 1'b1);
        send_word(32'h24, 32'h1111_1111, 1'b0);
        send_word(32'h28, 32'h2222_2222, 1'b0);
        send_word(32'h2C, 32'h3333_3333, 1'b0);
        for (int i = 0; i < 10; i++) begin
            repeat (100) @(negedge clk);
            if (i % 3 == 0) begin
                check("hold_req", {31'd0, mem_req}, 32'd1);
                check("hold_addr", mem_addr, 32'h20);
                check("hold_data", mem_wdata, 32'hA1B2_C3D4);
            end
        end
        check("ovr_err_overrun", {31'd0, err_overrun}, 32'd1);
        check("ovr_idle", {30'd0, dut.state_reg}, 32'd0);
        tick(1);
        mem_gnt = 1'b1;
        begin
            int k;
            k = 0;
            while (exp_q.size() != 0 && k < 20) begin
                tick(1);
                k++;
            end
            if (exp_q.size() != 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL ovr_grant_timeout: got %0d pending expected 0", exp_q.size());
            end
        end
        tick(5);
        check("ovr_word_cnt", {16'd0, word_cnt}, 32'd7);
        check("ovr_req_low", {31'd0, mem_req}, 32'd0);

        // ---------------- timeout ----------------
        send_hdr(32'h0000_1000);
        send_byte(8'hAA);
        send_byte(8'hBB);
        tick(TMO - 5);
        check("tmo_not_yet", {31'd0, err_timeout}, 32'd0);
        tick(10);
        check("tmo_err", {31'd0, err_timeout}, 32'd1);
        check("tmo_idle", {30'd0, dut.state_reg}, 32'd0);
        check("tmo_word_cnt", {16'd0, word_cnt}, 32'd7);
        check("tmo_fetch_before", {31'd0, fetch_en}, 32'd0);
        send_byte(8'h04);
        check("go_fetch_en", {31'd0, fetch_en}, 32'd1);

        // ---------------- reset mid-frame with request pending ----------------
        mem_gnt = 1'b0;
        send_hdr(32'h0000_0040);
        send_word(32'h40, 32'hCAFE_F00D, 1'b1);
        @(negedge clk);
        check("pre_rst_req", {31'd0, mem_req}, 32'd1);
        #2 reset = 1'b1;
        exp_q.delete();
        #1;
        check("arst_mem_req", {31'd0, mem_req}, 32'd0);
        check("arst_mem_addr", mem_addr, 32'd0);
        check("arst_mem_wdata", mem_wdata, 32'd0);
        check("arst_fetch_en", {31'd0, fetch_en}, 32'd0);
        check("arst_word_cnt", {16'd0, word_cnt}, 32'd0);
        check("arst_errs", {29'd0, err_overrun, err_cmd, err_timeout}, 32'd0);
        check("arst_state", {30'd0, dut.state_reg}, 32'd0);
        tick(2);
        reset = 1'b0;
        tick(1);
        mem_gnt = 1'b1;
        send_hdr(32'h0000_0050);
        send_word(32'h50, 32'h0BAD_CAFE, 1'b1);
        send_word(32'h54, 32'h1234_5678, 1'b1);
        send_word(32'h58, 32'h8765_4321, 1'b1);
        send_word(32'h5C, 32'hFEDC_BA98, 1'b1);
        tick(3);
        check("post_rst_word_cnt", {16'd0, word_cnt}, 32'd4);

        // ---------------- address wrap ----------------
        send_hdr(32'hFFFF_FFF0);
        send_word(32'hFFFF_FFF0, 32'hC001_0001, 1'b1);
        send_word(32'hFFFF_FFF4, 32'hC001_0002, 1'b1);
        send_word(32'hFFFF_FFF8, 32'hC001_0003, 1'b1);
        send_word(32'hFFFF_FFFC, 32'hC001_0004, 1'b1);
        tick(3);
        check("wrap_word_cnt", {16'd0, word_cnt}, 32'd8);
        check("wrap_addr_zero", dut.addr_reg, 32'd0);
        check("wrap_idle", {30'd0, dut.state_reg}, 32'd0);
        check("end_queue_empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
